// File: rtl/clk_reset_pkg.sv
// Shared types and default parameter values for the PLL-driven reset and
// CPU clock-enable generator.
package clk_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } crg_state_e;

    localparam int CLK_DIV_DEF     = 28;
    localparam int LOCK_FILTER_DEF = 1024;
    localparam int RESET_HOLD_DEF  = 16;

endpackage

// File: rtl/clk_reset_gen_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low clear, used to
// bring the PLL lock indicator into the CLK domain.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_reset_gen.sv
// System reset and CPU clock-enable generator: filters PLL lock, holds reset
// for a fixed number of CPU enable pulses, then releases it until lock drops.
module clk_reset_gen
    import clk_reset_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int LOCK_FILTER = LOCK_FILTER_DEF,
    parameter int RESET_HOLD  = RESET_HOLD_DEF
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       LOCKED,
    output logic       SYS_RESET_N,
    output logic       CPU_CLK_EN,
    output logic       READY,
    output logic [1:0] STATE
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FILT_W  = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int PULSE_W = $clog2(RESET_HOLD + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RESET_HOLD - 1);

    logic               lock_s;
    crg_state_e         state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [FILT_W-1:0]  filt_q, filt_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic               en_d;
    logic               tick;

    sync2 #(.WIDTH(1)) u_lock_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .d     (LOCKED),
        .q     (lock_s)
    );

    assign tick = (div_q == DIV_LAST);

    // Loss of lock is checked first in every state so it always wins over a
    // due pulse or a filter terminal count.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        filt_d  = '0;
        pulse_d = pulse_q;
        en_d    = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                pulse_d = '0;
                if (lock_s) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                pulse_d = '0;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (filt_q == FILT_LAST) begin
                    state_d = HOLD;
                end else begin
                    filt_d = filt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    pulse_d = '0;
                end else begin
                    div_d = tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        en_d    = 1'b1;
                        pulse_d = pulse_q + 1'b1;
                        if (pulse_q == PULSE_LAST) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    pulse_d = '0;
                end else begin
                    // The divider free-runs from HOLD so the enable keeps its phase.
                    div_d = tick ? '0 : div_q + 1'b1;
                    en_d  = tick;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                pulse_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= WAIT_LOCK;
            div_q       <= '0;
            filt_q      <= '0;
            pulse_q     <= '0;
            CPU_CLK_EN  <= 1'b0;
            SYS_RESET_N <= 1'b0;
            READY       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            filt_q      <= filt_d;
            pulse_q     <= pulse_d;
            CPU_CLK_EN  <= en_d;
            SYS_RESET_N <= (state_d == RUN);
            READY       <= (state_d == RUN);
        end
    end

    assign STATE = state_q;

endmodule
